// File: rtl/dvi_pkg.sv
// Shared types and constants for the DVI source scheduler.
// Pixel width, black level and scheduler FSM state encoding.
package dvi_pkg;

  localparam int RGB_W = 24;

  localparam logic [RGB_W-1:0] RGB_BLACK = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_OPEN
  } sched_st_e;

endpackage

// File: rtl/dvi_src_sched_rr_pick.sv
// Combinational round-robin picker.
// Search starts at i_ptr; i_excl masks the index just before i_ptr.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  input  logic          i_excl,
  output logic [N-1:0]  o_win,
  output logic          o_vld
);

  logic [N-1:0] w_req;

  always_comb begin
    w_req = i_req;
    o_win = '0;
    o_vld = 1'b0;
    // i_ptr is last winner + 1, so the current holder sits at i_ptr - 1
    for (int n = 0; n < N; n++) begin
      if (i_excl && n == (int'(i_ptr) + N - 1) % N)
        w_req[n] = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      for (int n = 0; n < N; n++) begin
        if (!o_vld && w_req[n] &&
            n == (int'(i_ptr) + k) % N) begin
          o_win[n] = 1'b1;
          o_vld    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dvi_src_sched.sv
// Frame-synchronous pixel source scheduler with minimum dwell.
// Grants change only on the cycle after a vsync-rise boundary pulse.
module dvi_src_sched
  import dvi_pkg::*;
#(
  parameter int   NUM_SRC    = 4,
  parameter int   MIN_FRAMES = 60,
  parameter logic VS_POL     = 1'b1
) (
  input  logic                     clk_40m_tree,
  input  logic                     reset_loc,
  input  logic                     vga_de,
  input  logic                     vga_hs,
  input  logic                     vga_vs,
  input  logic [NUM_SRC-1:0]       src_req,
  input  logic [RGB_W*NUM_SRC-1:0] src_rgb,
  output logic [NUM_SRC-1:0]       src_gnt,
  output logic                     switch_pulse,
  output logic [RGB_W-1:0]         out_rgb,
  output logic                     out_de,
  output logic                     out_hs,
  output logic                     out_vs
);

  localparam int CW = $clog2(MIN_FRAMES + 1);
  localparam int PW = $clog2(NUM_SRC);
  localparam logic [CW-1:0] LAST = CW'(MIN_FRAMES - 1);
  localparam logic [CW-1:0] SAT  = CW'(MIN_FRAMES);

  sched_st_e          r_st;
  logic [NUM_SRC-1:0] r_gnt;
  logic [PW-1:0]      r_ptr;
  logic [CW-1:0]      r_cnt;
  logic               r_vs_hist;
  logic               r_bnd;
  logic               r_pulse;
  logic [RGB_W-1:0]   r_rgb;
  logic               r_de;
  logic               r_hs;
  logic               r_vs;

  logic               w_vs_on;
  logic               w_cur_req;
  logic               w_eval;
  logic [CW-1:0]      w_cnt_inc;
  logic [NUM_SRC-1:0] w_win;
  logic               w_vld;
  logic [PW-1:0]      w_nxt;
  logic [RGB_W-1:0]   w_rgb;

  assign w_vs_on   = (vga_vs == VS_POL);
  assign w_cur_req = |(src_req & r_gnt);
  assign w_eval    = (r_st == ST_OPEN) || !w_cur_req ||
                     (r_cnt == LAST);
  assign w_cnt_inc = (r_cnt == SAT) ? SAT : r_cnt + 1'b1;

  rr_pick #(
    .N  (NUM_SRC),
    .PW (PW)
  ) u_pick (
    .i_req  (src_req),
    .i_ptr  (r_ptr),
    .i_excl (r_st != ST_IDLE),
    .o_win  (w_win),
    .o_vld  (w_vld)
  );

  always_comb begin
    w_nxt = '0;
    w_rgb = RGB_BLACK;
    for (int n = 0; n < NUM_SRC; n++) begin
      if (w_win[n]) w_nxt = PW'((n + 1) % NUM_SRC);
      if (r_gnt[n]) w_rgb = w_rgb | src_rgb[n*RGB_W +: RGB_W];
    end
  end

  always_ff @(posedge clk_40m_tree or posedge reset_loc) begin
    if (reset_loc) begin
      r_st      <= ST_IDLE;
      r_gnt     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_vs_hist <= 1'b1;
      r_bnd     <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_vs_hist <= w_vs_on;
      r_bnd     <= w_vs_on & ~r_vs_hist;
      r_pulse   <= 1'b0;
      if (r_bnd) begin
        if (r_st != ST_IDLE && !w_eval) begin
          r_cnt <= w_cnt_inc;
        end else if (w_vld) begin
          r_gnt   <= w_win;
          r_ptr   <= w_nxt;
          r_cnt   <= '0;
          r_st    <= ST_HOLD;
          r_pulse <= 1'b1;
        end else if (r_st != ST_IDLE && w_cur_req) begin
          r_cnt <= w_cnt_inc;
          r_st  <= ST_OPEN;
        end else if (r_st != ST_IDLE) begin
          r_gnt   <= '0;
          r_cnt   <= '0;
          r_st    <= ST_IDLE;
          r_pulse <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_40m_tree or posedge reset_loc) begin
    if (reset_loc) begin
      r_rgb <= RGB_BLACK;
      r_de  <= 1'b0;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
    end else begin
      r_rgb <= (vga_de && |r_gnt) ? w_rgb : RGB_BLACK;
      r_de  <= vga_de;
      r_hs  <= vga_hs;
      r_vs  <= vga_vs;
    end
  end

  assign src_gnt      = r_gnt;
  assign switch_pulse = r_pulse;
  assign out_rgb      = r_rgb;
  assign out_de       = r_de;
  assign out_hs       = r_hs;
  assign out_vs       = r_vs;

endmodule

// File: tb/tb_dvi_src_sched.sv
// Directed bench for dvi_src_sched with MIN_FRAMES=3.
// Boundaries are driven explicitly; grants are checked after each.
module tb_dvi_src_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        de  = 1'b0;
  logic        hs  = 1'b0;
  logic        vs  = 1'b0;
  logic [3:0]  req = '0;
  logic [95:0] rgb;
  logic [3:0]  gnt;
  logic        pulse;
  logic [23:0] orgb;
  logic        ode;
  logic        ohs;
  logic        ovs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dvi_src_sched #(
    .NUM_SRC    (4),
    .MIN_FRAMES (3),
    .VS_POL     (1'b1)
  ) dut (
    .clk_40m_tree (clk),
    .reset_loc    (rst),
    .vga_de       (de),
    .vga_hs       (hs),
    .vga_vs       (vs),
    .src_req      (req),
    .src_rgb      (rgb),
    .src_gnt      (gnt),
    .switch_pulse (pulse),
    .out_rgb      (orgb),
    .out_de       (ode),
    .out_hs       (ohs),
    .out_vs       (ovs)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bnd();
    vs = 1'b0;
    tick();
    tick();
    vs = 1'b1;
    tick();
    tick();
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_sw(input string tag,
                        input logic [3:0] g,
                        input logic p);
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_pulse"}, 32'(pulse), 32'(p));
  endtask

  initial begin
    rgb = {24'hAABBCC, 24'h778899, 24'h445566, 24'h112233};
    de  = 1'b1;
    hs  = 1'b1;
    vs  = 1'b1;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_pulse", 32'(pulse), 32'h0);
    chk("rst_rgb", 32'(orgb), 32'h0);
    chk("rst_tim", 32'({ode, ohs, ovs}), 32'h0);
    de = 1'b0;
    hs = 1'b0;
    vs = 1'b0;
    rst = 1'b0;
    tick();
    tick();

    req = 4'b0001;
    tick();
    tick();
    chk_sw("midframe", 4'b0000, 1'b0);
    vs = 1'b1;
    tick();
    chk("pre_bnd_gnt", 32'(gnt), 32'h0);
    chk("out_vs", 32'(ovs), 32'h1);
    tick();
    chk_sw("b0", 4'b0001, 1'b1);
    de = 1'b1;
    hs = 1'b1;
    tick();
    chk("b0_pulse_end", 32'(pulse), 32'h0);
    chk("rgb_src0", 32'(orgb), 32'h112233);
    chk("de_hs", 32'({ode, ohs}), 32'h3);
    rgb[23:0] = 24'h010203;
    tick();
    chk("rgb_track", 32'(orgb), 32'h010203);
    de = 1'b0;
    tick();
    chk("rgb_de_low", 32'(orgb), 32'h0);
    chk("de_low", 32'(ode), 32'h0);

    req = 4'b0011;
    bnd();
    chk_sw("b1", 4'b0001, 1'b0);
    bnd();
    chk_sw("b2", 4'b0001, 1'b0);
    bnd();
    chk_sw("b3", 4'b0010, 1'b1);
    bnd();
    chk_sw("b4", 4'b0010, 1'b0);
    bnd();
    chk_sw("b5", 4'b0010, 1'b0);
    bnd();
    chk_sw("b6", 4'b0001, 1'b1);

    bnd();
    chk_sw("b7", 4'b0001, 1'b0);
    req = 4'b0100;
    bnd();
    chk_sw("b8_release", 4'b0100, 1'b1);

    req = 4'b0000;
    bnd();
    chk_sw("b9_none", 4'b0000, 1'b1);
    de = 1'b1;
    tick();
    chk("idle_rgb", 32'(orgb), 32'h0);
    chk("idle_de", 32'(ode), 32'h1);
    de = 1'b0;

    vs = 1'b0;
    tick();
    req = 4'b1000;
    tick();
    tick();
    req = 4'b0000;
    tick();
    vs = 1'b1;
    tick();
    tick();
    chk_sw("b10_glitch", 4'b0000, 1'b0);

    req = 4'b1000;
    bnd();
    chk_sw("b11", 4'b1000, 1'b1);
    bnd();
    bnd();
    bnd();
    chk_sw("b14_keep", 4'b1000, 1'b0);
    req = 4'b1001;
    bnd();
    chk_sw("b15_open", 4'b0001, 1'b1);

    de = 1'b1;
    bnd();
    tick();
    chk("pre_rst_rgb", 32'(orgb), 32'h010203);
    #2;
    rst = 1'b1;
    #1;
    chk_sw("async_rst", 4'b0000, 1'b0);
    chk("async_rgb", 32'(orgb), 32'h0);
    chk("async_tim", 32'({ode, ohs, ovs}), 32'h0);
    #1;
    rst = 1'b0;
    req = 4'b0001;
    repeat (4) tick();
    chk_sw("no_false_bnd", 4'b0000, 1'b0);
    bnd();
    chk_sw("post_rst_bnd", 4'b0001, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
